// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-array datapath.
package snn_pkg;

  localparam int ACC_WIDTH = 16;

  typedef logic [ACC_WIDTH-1:0] acc_t;

endpackage : snn_pkg

// File: rtl/sat_counter.sv
// Single-register up-counter with optional saturation at the all-ones value.
module sat_counter
  import snn_pkg::*;
#(
  parameter int               WIDTH    = ACC_WIDTH,
  parameter bit               SATURATE = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH:0]   sum_s;

  // The extra top bit of the sum is the carry, i.e. the "already at max" flag.
  assign sum_s = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};

  // Next-state: hold, increment, or hold at max when saturating.
  always_comb begin
    q_d = q_q;
    if (inc) begin
      if (SATURATE && sum_s[WIDTH]) begin
        q_d = q_q;
      end else begin
        q_d = sum_s[WIDTH-1:0];
      end
    end else begin
      q_d = q_q;
    end
  end

  // Count register; reset wins over any increment on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : sat_counter

// File: rtl/accumulator_element.sv
// Per-neuron spike accumulator: counts one spike per clock into a registered count.
module accumulator_element
  import snn_pkg::*;
#(
  parameter int               WIDTH    = ACC_WIDTH,
  parameter bit               SATURATE = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             spike,
  output logic [WIDTH-1:0] accumulated_spikes
);

  logic inc_s;

  // In simulation an unknown spike is not counted; hardware sees a plain bit.
`ifdef SYNTHESIS
  assign inc_s = spike;
`else
  assign inc_s = (spike === 1'b1);
`endif

  sat_counter #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE),
    .RST_VAL  (RST_VAL)
  ) u_sat_counter (
    .clk (clk),
    .rst (rstn),
    .inc (inc_s),
    .q   (accumulated_spikes)
  );

endmodule : accumulator_element

// File: tb/tb_accumulator_element.sv
// Directed bench for accumulator_element: reset, burst, random, saturate, wrap, mid-count reset.
module tb_accumulator_element;

  logic        clk;
  logic        rst16, spk16;
  logic [15:0] out16;
  logic        rst_s4, spk_s4;
  logic [3:0]  out_s4;
  logic        rst_w4, spk_w4;
  logic [3:0]  out_w4;

  int checks = 0;
  int errors = 0;

  accumulator_element #(.WIDTH(16), .SATURATE(1'b1), .RST_VAL(16'd0)) dut16 (
    .clk(clk), .rstn(rst16), .spike(spk16), .accumulated_spikes(out16));
  accumulator_element #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(4'd0)) dut_sat (
    .clk(clk), .rstn(rst_s4), .spike(spk_s4), .accumulated_spikes(out_s4));
  accumulator_element #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(4'd0)) dut_wrap (
    .clk(clk), .rstn(rst_w4), .spike(spk_w4), .accumulated_spikes(out_w4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned seed_v;
    logic [15:0] model;
    logic        bit_v;

    rst16 = 1'b1; spk16 = 1'b1;
    rst_s4 = 1'b1; spk_s4 = 1'b0;
    rst_w4 = 1'b1; spk_w4 = 1'b0;

    // Reset with spike high for two edges
    step(); chk("reset_e1", out16, 16'd0);
    step(); chk("reset_e2", out16, 16'd0);
    chk("reset_sat4", {12'd0, out_s4}, 16'd0);
    chk("reset_wrap4", {12'd0, out_w4}, 16'd0);

    // Burst: five spikes then three idle cycles
    rst16 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      spk16 = 1'b1;
      step(); chk($sformatf("burst_%0d", i), out16, 16'(i));
    end
    spk16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("burst_hold_%0d", i), out16, 16'd5);
    end

    // Random stream against a popcount scoreboard
    rst16 = 1'b1; spk16 = 1'b0;
    step(); chk("rand_reset", out16, 16'd0);
    rst16 = 1'b0;
    seed_v = $urandom(123);
    model = 16'd0;
    for (int i = 0; i < 200; i++) begin
      bit_v = 1'($urandom_range(0, 1));
      spk16 = bit_v;
      if (bit_v) model = model + 16'd1;
      step(); chk($sformatf("rand_%0d", i), out16, model);
    end

    // Mid-count reset: count to 9, reset with spike high, release with spike high
    rst16 = 1'b1; spk16 = 1'b0;
    step();
    rst16 = 1'b0; spk16 = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("mid_count9", out16, 16'd9);
    rst16 = 1'b1; spk16 = 1'b1;
    step(); chk("mid_reset", out16, 16'd0);
    rst16 = 1'b0; spk16 = 1'b1;
    step(); chk("mid_after", out16, 16'd1);
    spk16 = 1'b0;

    // Saturation, 4 bits: 20 spikes, pinned at 15 from the 15th on
    rst_s4 = 1'b0; spk_s4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat_%0d", i), {12'd0, out_s4}, (i < 15) ? 16'(i) : 16'd15);
    end
    spk_s4 = 1'b0;

    // Wrap, 4 bits: 17 spikes, 15 -> 0 -> 1
    rst_w4 = 1'b0; spk_w4 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("wrap_%0d", i), {12'd0, out_w4}, 16'(i % 16));
    end
    spk_w4 = 1'b0;
    step(); chk("wrap_hold", {12'd0, out_w4}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_accumulator_element
